bcd2_seg_scan: RTL

//  Display end of the two-digit BCD counter interface. It consumes tens/ones BCD digits and drives a

---
 rtl/seg_scan_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd2_seg_scan.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and segment constants for the two-digit 7-segment scanner.
package seg_scan_pkg;

    // Scan order: ones lit, gap, tens lit, gap
    typedef enum logic [1:0] {
        S_ON0  = 2'd0,
        S_GAP0 = 2'd1,
        S_ON1  = 2'd2,
        S_GAP1 = 2'd3
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup, anything outside 0..9 is a dash
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd2_seg_scan.sv
// Two-digit multiplexed 7-segment scanner with per-frame digit snapshot,
// inter-digit blanking gaps, leading-zero blanking and configurable polarity.
//
// state  | meaning
// S_ON0  | ones digit slot (first cycle with en=1 is the frame start)
// S_GAP0 | all digits dark after ones
// S_ON1  | tens digit slot (blanked when tens snapshot is 0 and LZB=1)
// S_GAP1 | all digits dark after tens
module bcd2_seg_scan
    import seg_scan_pkg::*;
#(
    parameter int ON_CYC      = 50000,
    parameter int GAP_CYC     = 500,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1,
    parameter int LZB         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    localparam logic [6:0] SEG_IDLE = (SEG_ACT_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [1:0] AN_IDLE  = (AN_ACT_LOW != 0) ? 2'b11 : 2'b00;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    state_t           disp_state_q, disp_state_d;
    logic             disp_ok_q, disp_ok_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             tick_q, tick_d;

    logic             frame_start;
    logic [3:0]       digit_sel;
    logic [6:0]       digit_seg;
    logic [6:0]       seg_hi;
    logic [1:0]       an_hi;

    assign frame_start = en && (state_q == S_ON0) && (timer_q == ON_LOAD);

    // Scan FSM and down-counting slot timer; en=0 parks it at frame start
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!en) begin
            state_d = S_ON0;
            timer_d = ON_LOAD;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
        end else begin
            case (state_q)
                S_ON0: begin
                    if (GAP_CYC > 0) begin
                        state_d = S_GAP0;
                        timer_d = GAP_LOAD;
                    end else begin
                        state_d = S_ON1;
                        timer_d = ON_LOAD;
                    end
                end
                S_GAP0: begin
                    state_d = S_ON1;
                    timer_d = ON_LOAD;
                end
                S_ON1: begin
                    if (GAP_CYC > 0) begin
                        state_d = S_GAP1;
                        timer_d = GAP_LOAD;
                    end else begin
                        state_d = S_ON0;
                        timer_d = ON_LOAD;
                    end
                end
                default: begin
                    state_d = S_ON0;
                    timer_d = ON_LOAD;
                end
            endcase
        end
    end

    // Snapshot capture at frame start; display pipeline lags the FSM by one cycle
    // so the freshly captured digits are what the ones slot shows
    always_comb begin
        tens_d       = frame_start ? tens : tens_q;
        ones_d       = frame_start ? ones : ones_q;
        tick_d       = frame_start;
        disp_state_d = state_q;
        disp_ok_d    = en;
    end

    assign digit_sel = (disp_state_q == S_ON1) ? tens_q : ones_q;

    bcd_to_seg7 u_dec (
        .bcd (digit_sel),
        .seg (digit_seg)
    );

    // Output pattern: dark unless enabled now and in the previous cycle
    always_comb begin
        seg_hi = SEG_OFF;
        an_hi  = 2'b00;
        if (en && disp_ok_q) begin
            case (disp_state_q)
                S_ON0: begin
                    seg_hi = digit_seg;
                    an_hi  = 2'b01;
                end
                S_ON1: begin
                    if (!((LZB != 0) && (tens_q == 4'd0))) begin
                        seg_hi = digit_seg;
                        an_hi  = 2'b10;
                    end
                end
                default: begin
                    seg_hi = SEG_OFF;
                    an_hi  = 2'b00;
                end
            endcase
        end
        seg_d = (SEG_ACT_LOW != 0) ? ~seg_hi : seg_hi;
        an_d  = (AN_ACT_LOW != 0) ? ~an_hi : an_hi;
    end

    // All state and outputs registered; synchronous reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ON0;
            timer_q      <= ON_LOAD;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            disp_state_q <= S_ON0;
            disp_ok_q    <= 1'b0;
            seg_q        <= SEG_IDLE;
            an_q         <= AN_IDLE;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            disp_state_q <= disp_state_d;
            disp_ok_q    <= disp_ok_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            tick_q       <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
